// File: rtl/sys_umuldiv_ext.sv
// Sequential (mul1*mul2)/div unit with signed/unsigned mode and optional rounding.
// Fixed latency: NB_MUL2 multiply steps, NP divide steps, then one fix-up cycle.
module sys_umuldiv_ext #(
  parameter int NB_MUL1 = 16,
  parameter int NB_MUL2 = 16,
  parameter int NB_DIV  = 16,
  localparam int NP     = NB_MUL1 + NB_MUL2,
  localparam int NBC    = $clog2(NP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              round,
  input  logic [NB_MUL1-1:0] mul1,
  input  logic [NB_MUL2-1:0] mul2,
  input  logic [NB_DIV-1:0]  div,
  output logic              busy,
  output logic              done,
  output logic [NP-1:0]     result,
  output logic [NB_DIV-1:0] remainder,
  output logic              div_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [NBC-1:0]     cnt;
  logic [NP:0]        acc;
  logic [NB_MUL1-1:0] mag1;
  logic [NB_DIV-1:0]  dmag;
  logic [NB_DIV-1:0]  rem;
  logic               q_neg;
  logic               r_neg;
  logic               rnd;

  logic [NB_MUL1-1:0] addend;
  logic [NB_MUL1:0]   mul_sum;
  logic [NB_DIV:0]    trial;
  logic               take;
  logic [NB_DIV-1:0]  trial_diff;
  logic               round_up;
  logic [NP-1:0]      q_mag;
  logic [NP-1:0]      q_signed;
  logic [NB_DIV-1:0]  r_signed;

  // Multiply: acc holds {partial sum, unused multiplier bits}; divide: acc holds the shifting dividend/quotient.
  always_comb begin
    addend     = acc[0] ? mag1 : {NB_MUL1{1'b0}};
    mul_sum    = acc[NP:NB_MUL2] + {1'b0, addend};
    trial      = {rem, acc[NP-1]};
    take       = trial >= {1'b0, dmag};
    trial_diff = trial[NB_DIV-1:0] - dmag;
    round_up   = rnd && ({rem, 1'b0} >= {1'b0, dmag});
    q_mag      = acc[NP-1:0] + NP'(round_up);
    q_signed   = q_neg ? -q_mag : q_mag;
    r_signed   = r_neg ? -rem : rem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mag1      <= '0;
      dmag      <= '0;
      rem       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      rnd       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // N-bit negation of the most negative value yields 2^(N-1), which is its exact unsigned magnitude.
            mag1  <= (signed_mode && mul1[NB_MUL1-1]) ? -mul1 : mul1;
            acc   <= {{(NB_MUL1+1){1'b0}},
                      ((signed_mode && mul2[NB_MUL2-1]) ? -mul2 : mul2)};
            dmag  <= (signed_mode && div[NB_DIV-1]) ? -div : div;
            r_neg <= signed_mode && (mul1[NB_MUL1-1] ^ mul2[NB_MUL2-1]);
            q_neg <= signed_mode && (mul1[NB_MUL1-1] ^ mul2[NB_MUL2-1] ^ div[NB_DIV-1]);
            rnd   <= round;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[NB_MUL2-1:0]} >> 1;
          if (cnt == NBC'(NB_MUL2 - 1)) begin
            cnt   <= '0;
            state <= DIV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          rem <= take ? trial_diff : trial[NB_DIV-1:0];
          acc <= {1'b0, acc[NP-2:0], take};
          if (cnt == NBC'(NP - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (dmag == '0) begin
            result    <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
          end else begin
            result    <= q_signed;
            remainder <= r_signed;
            div_zero  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
